// File: rtl/sobel_edge_pipe.sv
// Streaming 3x3 Sobel edge detector with ready/valid handshake.
// Three stages (window+partial sums, |dx|+|dy|, output select) that all advance together on in_ready.
module sobel_edge_pipe #(
  parameter int PIX_W    = 16,
  parameter int ROW_SIZE = 180,
  parameter int SHIFT    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] threshold,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW     = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int SW     = PIX_W + 2;
  localparam int GW     = PIX_W + 3;
  localparam int STAGES = 3;

  typedef logic [PIX_W-1:0] pix_t;

  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;
  logic            acc, adv;
  logic [CW-1:0]   col, col_eff, col_nxt;
  logic [1:0]      row, row_eff, row_nxt;
  logic            col_last;

  pix_t lb1 [ROW_SIZE];
  pix_t lb2 [ROW_SIZE];
  // x0 holds column c-2, x1 column c-1, for top/mid/bottom window rows
  pix_t t0, t1, m0, m1, b0, b1;
  pix_t w0, w1, w2, w3, w4, w5, w6, w7, w8;

  logic [SW-1:0] gx1, gx2, gy1, gy2;
  logic          border;

  logic [SW-1:0] s1_gx1, s1_gx2, s1_gy1, s1_gy2;
  pix_t          s1_w4, s1_thr;
  logic [1:0]    s1_mode;
  logic          s1_bdr;

  logic [SW-1:0] dx, dy;
  logic [GW-1:0] g, m;

  logic [GW-1:0] s2_m;
  pix_t          s2_w4, s2_thr;
  logic [1:0]    s2_mode;
  logic          s2_bdr;

  pix_t res, out_q;

  assign out_valid = vld_q[STAGES] & ~reset;
  assign out_data  = reset ? '0 : out_q;
  assign in_ready  = !out_valid || out_ready;
  assign adv       = in_ready;
  assign acc       = in_valid & in_ready & ~reset;
  assign vld_pipe  = {vld_q, acc};

  // counter position of the pixel being accepted; sof forces (0,0)
  assign col_eff  = in_sof ? '0 : col;
  assign row_eff  = in_sof ? '0 : row;
  assign col_last = (col_eff == CW'(ROW_SIZE - 1));
  assign col_nxt  = col_last ? '0 : col_eff + CW'(1);
  assign row_nxt  = !col_last ? row_eff : (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;

  always_comb begin
    w0 = t0;  w1 = t1;  w2 = lb2[col_eff];
    w3 = m0;  w4 = m1;  w5 = lb1[col_eff];
    w6 = b0;  w7 = b1;  w8 = in_data;
    gx1 = SW'(w0) + (SW'(w3) << 1) + SW'(w6);
    gx2 = SW'(w2) + (SW'(w5) << 1) + SW'(w8);
    gy1 = SW'(w0) + (SW'(w1) << 1) + SW'(w2);
    gy2 = SW'(w6) + (SW'(w7) << 1) + SW'(w8);
    border = (row_eff < 2'd2) || (col_eff < CW'(2));
  end

  always_comb begin
    dx = (s1_gx1 >= s1_gx2) ? s1_gx1 - s1_gx2 : s1_gx2 - s1_gx1;
    dy = (s1_gy1 >= s1_gy2) ? s1_gy1 - s1_gy2 : s1_gy2 - s1_gy1;
    g  = GW'(dx) + GW'(dy);
    m  = g >> SHIFT;
  end

  always_comb begin
    res = '0;
    case (s2_mode)
      2'b10:   res = s2_w4;
      2'b01:   res = (!s2_bdr && (s2_m >= GW'(s2_thr))) ? '1 : '0;
      default: if (!s2_bdr) res = (|s2_m[GW-1:PIX_W]) ? '1 : s2_m[PIX_W-1:0];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      col   <= '0;
      row   <= '0;
      out_q <= '0;
    end else begin
      if (adv) begin
        vld_q <= vld_pipe[STAGES-1:0];
        out_q <= res;
      end
      if (acc) begin
        col <= col_nxt;
        row <= row_nxt;
      end
    end
  end

  // line buffers, window and stage datapath carry no reset; border masking hides stale values
  always_ff @(posedge clock) begin
    if (acc) begin
      lb1[col_eff] <= in_data;
      lb2[col_eff] <= lb1[col_eff];
      t0 <= t1;  t1 <= w2;
      m0 <= m1;  m1 <= w5;
      b0 <= b1;  b1 <= in_data;
    end
    if (adv) begin
      s1_gx1  <= gx1;
      s1_gx2  <= gx2;
      s1_gy1  <= gy1;
      s1_gy2  <= gy2;
      s1_w4   <= w4;
      s1_thr  <= threshold;
      s1_mode <= mode;
      s1_bdr  <= border;
      s2_m    <= m;
      s2_w4   <= s1_w4;
      s2_thr  <= s1_thr;
      s2_mode <= s1_mode;
      s2_bdr  <= s1_bdr;
    end
  end

endmodule

// File: tb/tb_sobel_edge_pipe.sv
// Directed bench for sobel_edge_pipe on an 8x8 frame; a SHIFT=0 twin covers saturation.
module tb_sobel_edge_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid, in_sof, in_ready, in_ready0;
  logic [1:0]  mode;
  logic [15:0] threshold;
  logic [15:0] out_data, out_data0;
  logic        out_valid, out_valid0, out_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit tmo     = 1'b0;

  logic [15:0] got[$], got0[$];
  int          got_cyc[$], acc_cyc[$];

  sobel_edge_pipe #(.PIX_W(16), .ROW_SIZE(8), .SHIFT(2)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .mode(mode), .threshold(threshold), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready));

  sobel_edge_pipe #(.PIX_W(16), .ROW_SIZE(8), .SHIFT(0)) dut0 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready0), .mode(mode), .threshold(threshold), .out_data(out_data0),
    .out_valid(out_valid0), .out_ready(out_ready));

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (out_valid && out_ready) begin
      got.push_back(out_data);
      got_cyc.push_back(cyc);
    end
    if (out_valid0 && out_ready) got0.push_back(out_data0);
    if (in_valid && in_ready && !reset) acc_cyc.push_back(cyc);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] pix(input int kind, input int amp, input int r, input int c);
    if (kind == 0) return 16'(amp);
    if (kind == 1) return (c >= 4) ? 16'(amp) : 16'd0;
    return 16'(r * 16 + c + 1);
  endfunction

  task automatic clear_q();
    got.delete(); got0.delete(); got_cyc.delete(); acc_cyc.delete();
    tmo = 1'b0;
  endtask

  task automatic send_pix(input logic [15:0] d, input logic sof, input logic [1:0] md,
                          input logic [15:0] th);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_sof = sof; mode = md; threshold = th;
    @(negedge clock);
    while (!in_ready && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 1000) tmo = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_frame(input int kind, input int amp, input logic [1:0] md,
                            input logic [15:0] th, input bit sof_first);
    for (int i = 0; i < 64; i++)
      send_pix(pix(kind, amp, i / 8, i % 8), sof_first && (i == 0), md, th);
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (got.size() < n && k < 400) begin
      @(negedge clock);
      k++;
    end
    if (k >= 400) tmo = 1'b1;
    repeat (4) @(negedge clock);
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    clear_q();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'd1234; in_sof = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== 16'd0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_state cyc%0d: out_valid=%b out_data=%h in_ready=%b, want 0/0000/1",
                 j, out_valid, out_data, in_ready);
      end
    end
    @(posedge clock); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clock);
    n_tests++;
    if (got.size() !== 0 || acc_cyc.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_discard: outputs=%0d accepts=%0d, want 0/0", got.size(), acc_cyc.size());
    end
    @(posedge clock); #1;
  endtask

  task automatic test_flat();
    clear_q();
    send_frame(0, 100, 2'b00, 16'd0, 1'b1);
    drain(64);
    n_tests++;
    if (tmo || got.size() !== 64) begin
      n_fail++;
      $display("FAIL flat_count: got %0d outputs (timeout=%0d), want 64", got.size(), tmo);
    end
    for (int i = 0; i < got.size() && i < 64; i++) begin
      n_tests++;
      if (got[i] !== 16'd0) begin
        n_fail++;
        $display("FAIL flat[%0d]: got %0d, want 0", i, got[i]);
      end
      n_tests++;
      if (got_cyc[i] - acc_cyc[i] !== 3) begin
        n_fail++;
        $display("FAIL flat_latency[%0d]: got %0d cycles, want 3", i, got_cyc[i] - acc_cyc[i]);
      end
    end
  endtask

  task automatic test_step();
    logic [15:0] exp;
    clear_q();
    send_frame(1, 1000, 2'b11, 16'd0, 1'b1);
    drain(64);
    n_tests++;
    if (tmo || got.size() !== 64) begin
      n_fail++;
      $display("FAIL step_count: got %0d outputs, want 64", got.size());
    end
    for (int i = 0; i < got.size() && i < 64; i++) begin
      exp = (i / 8 >= 2 && (i % 8 == 4 || i % 8 == 5)) ? 16'd1000 : 16'd0;
      n_tests++;
      if (got[i] !== exp) begin
        n_fail++;
        $display("FAIL step(%0d,%0d): got %0d, want %0d", i / 8, i % 8, got[i], exp);
      end
    end
  endtask

  task automatic test_saturate();
    logic [15:0] exp, exp0;
    clear_q();
    send_frame(1, 20000, 2'b00, 16'd0, 1'b1);
    drain(64);
    n_tests++;
    if (tmo || got0.size() !== 64 || got.size() !== 64) begin
      n_fail++;
      $display("FAIL sat_count: got %0d/%0d outputs, want 64", got0.size(), got.size());
    end
    for (int i = 0; i < got0.size() && i < got.size() && i < 64; i++) begin
      exp0 = (i / 8 >= 2 && (i % 8 == 4 || i % 8 == 5)) ? 16'hFFFF : 16'd0;
      exp  = (i / 8 >= 2 && (i % 8 == 4 || i % 8 == 5)) ? 16'd20000 : 16'd0;
      n_tests++;
      if (got0[i] !== exp0) begin
        n_fail++;
        $display("FAIL sat_shift0(%0d,%0d): got %h, want %h", i / 8, i % 8, got0[i], exp0);
      end
      n_tests++;
      if (got[i] !== exp) begin
        n_fail++;
        $display("FAIL sat_shift2(%0d,%0d): got %0d, want %0d", i / 8, i % 8, got[i], exp);
      end
    end
  endtask

  task automatic test_threshold();
    logic [15:0] exp;
    clear_q();
    send_frame(1, 1000, 2'b01, 16'd500, 1'b1);
    send_frame(1, 1000, 2'b01, 16'd1001, 1'b1);
    drain(128);
    n_tests++;
    if (tmo || got.size() !== 128) begin
      n_fail++;
      $display("FAIL thr_count: got %0d outputs, want 128", got.size());
    end
    for (int i = 0; i < got.size() && i < 128; i++) begin
      exp = (i < 64 && (i / 8) >= 2 && (i % 8 == 4 || i % 8 == 5)) ? 16'hFFFF : 16'd0;
      n_tests++;
      if (got[i] !== exp) begin
        n_fail++;
        $display("FAIL thr[%0d] (thr %0d): got %h, want %h", i, (i < 64) ? 500 : 1001, got[i], exp);
      end
    end
  endtask

  task automatic test_passthrough();
    logic [15:0] exp;
    int r, c;
    clear_q();
    for (int i = 0; i < 3; i++) send_pix(16'd7, 1'b0, 2'b10, 16'd0);
    send_frame(2, 0, 2'b10, 16'd0, 1'b1);
    drain(67);
    n_tests++;
    if (tmo || got.size() !== 67) begin
      n_fail++;
      $display("FAIL pass_count: got %0d outputs, want 67", got.size());
    end
    for (int i = 0; i < 64 && i + 3 < got.size(); i++) begin
      r = i / 8; c = i % 8;
      if (r >= 2 && c >= 2) begin
        exp = 16'((r - 1) * 16 + c);
        n_tests++;
        if (got[i + 3] !== exp) begin
          n_fail++;
          $display("FAIL pass(%0d,%0d): got %0d, want %0d", r, c, got[i + 3], exp);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp, hold;
    clear_q();
    fork
      send_frame(1, 1000, 2'b00, 16'd0, 1'b1);
      begin
        repeat (20) @(posedge clock);
        #1 out_ready = 1'b0;
        @(negedge clock);
        hold = out_data;
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_ready: in_ready=%b out_valid=%b, want 0/1", in_ready, out_valid);
        end
        for (int j = 0; j < 4; j++) begin
          @(negedge clock);
          n_tests++;
          if (out_data !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: out_data=%0d out_valid=%b in_ready=%b, want %0d/1/0",
                     j, out_data, out_valid, in_ready, hold);
          end
        end
        @(posedge clock); #1 out_ready = 1'b1;
      end
    join
    drain(64);
    n_tests++;
    if (tmo || got.size() !== 64) begin
      n_fail++;
      $display("FAIL bp_count: got %0d outputs, want 64", got.size());
    end
    for (int i = 0; i < got.size() && i < 64; i++) begin
      exp = (i / 8 >= 2 && (i % 8 == 4 || i % 8 == 5)) ? 16'd1000 : 16'd0;
      n_tests++;
      if (got[i] !== exp) begin
        n_fail++;
        $display("FAIL bp(%0d,%0d): got %0d, want %0d", i / 8, i % 8, got[i], exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    clear_q();
    for (int i = 0; i < 29; i++) send_pix(pix(1, 1000, i / 8, i % 8), i == 0, 2'b00, 16'd0);
    in_valid = 1'b1; in_data = pix(1, 1000, 3, 5); in_sof = 1'b0; reset = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clock);
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== 16'd0) begin
        n_fail++;
        $display("FAIL midreset_out[%0d]: out_valid=%b out_data=%0d, want 0/0", j, out_valid, out_data);
      end
    end
    @(posedge clock); #1;
    reset = 1'b0; in_valid = 1'b0;
    clear_q();
    send_frame(1, 1000, 2'b00, 16'd0, 1'b0);
    drain(64);
    n_tests++;
    if (tmo || got.size() !== 64) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d outputs, want 64", got.size());
    end
    for (int i = 0; i < got.size() && i < 64; i++) begin
      exp = (i / 8 >= 2 && (i % 8 == 4 || i % 8 == 5)) ? 16'd1000 : 16'd0;
      n_tests++;
      if (got[i] !== exp) begin
        n_fail++;
        $display("FAIL midreset(%0d,%0d): got %0d, want %0d", i / 8, i % 8, got[i], exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    mode = 2'b00; threshold = '0; out_ready = 1'b1;
    @(posedge clock); #1;
    test_reset();
    test_flat();
    test_step();
    test_saturate();
    test_threshold();
    test_passthrough();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
